// File: rtl/swd_pkg.sv
// ============================================================================
// swd_pkg : shared types and constants for the SWD host engine
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package swd_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LRESET   = 4'd1,
    REQ      = 4'd2,
    TRN1     = 4'd3,
    ACK      = 4'd4,
    RDATA    = 4'd5,
    TRN2     = 4'd6,
    WDATA    = 4'd7,
    IDLE_CLK = 4'd8,
    DONE     = 4'd9
  } swd_state_t;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  localparam int REQ_BITS  = 8;
  localparam int ACK_BITS  = 3;
  localparam int DATA_BITS = 32;

  // Request byte in wire order (bit0 goes out first): start, APnDP, RnW, A2, A3, parity, stop, park.
  function automatic logic [7:0] swd_req_byte(input logic apndp, input logic rnw,
                                              input logic [1:0] addr);
    return {1'b1, 1'b0, ^{apndp, rnw, addr}, addr[1], addr[0], rnw, apndp, 1'b1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/swd_bit_timer.sv
// ============================================================================
// swd_bit_timer : SWCLK divider; each bit is CLK_DIV low cycles then CLK_DIV high
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module swd_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic ext_clock,
  input  logic reset,
  input  logic run_i,
  output logic drive_tick_o,
  output logic sample_tick_o,
  output logic swclk_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          swclk_q, swclk_d;

  always_comb begin
    div_d   = div_q;
    swclk_d = swclk_q;
    if (!run_i) begin
      div_d   = '0;
      swclk_d = 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_d   = '0;
      swclk_d = ~swclk_q;
    end else begin
      div_d   = div_q + 1'b1;
    end
  end

  always_ff @(posedge ext_clock or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      swclk_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      swclk_q <= swclk_d;
    end
  end

  // drive_tick is the last high cycle: anything registered on it appears on
  // the first low-phase cycle of the next bit.
  assign drive_tick_o  = run_i &  swclk_q & (div_q == DIV_LAST);
  assign sample_tick_o = run_i & ~swclk_q & (div_q == DIV_LAST);
  assign swclk_o       = swclk_q;

endmodule

`default_nettype wire

// File: rtl/swd_host_engine.sv
// ============================================================================
// swd_host_engine : SWD initiator turning one host command into a wire sequence.
// rsp_valid is registered: it is seen in the cycle after the (2*CLK_DIV*bits)-th
// clock edge following the accepting edge (384 edges for a read with defaults).
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module swd_host_engine
  import swd_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int IDLE_CYCLES = 2,
  parameter int LRESET_BITS = 56
) (
  input  logic        ext_clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_lreset,
  input  logic        cmd_apndp,
  input  logic        cmd_rnw,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [2:0]  rsp_ack,
  output logic [31:0] rsp_rdata,
  output logic        rsp_parity_err,
  output logic        swclk_o,
  output logic        swdio_o,
  output logic        swdio_oe,
  input  logic        swdio_i
);

  swd_state_t  state_q;
  logic [5:0]  cnt_q;
  logic [6:0]  req_q;
  logic [32:0] wsh_q;
  logic [31:0] rdata_q;
  logic        rpar_q;
  logic [2:0]  ack_q;
  logic        rnw_q;
  logic        cmd_ready_q, rsp_valid_q, rsp_perr_q, swdio_o_q, swdio_oe_q;
  logic [2:0]  rsp_ack_q;
  logic [31:0] rsp_rdata_q;

  logic       run, drive_tick, sample_tick;
  logic [7:0] req_word;

  assign run      = (state_q != IDLE) && (state_q != DONE);
  assign req_word = swd_req_byte(cmd_apndp, cmd_rnw, cmd_addr);

  swd_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .ext_clock    (ext_clock),
    .reset        (reset),
    .run_i        (run),
    .drive_tick_o (drive_tick),
    .sample_tick_o(sample_tick),
    .swclk_o      (swclk_o)
  );

  always_ff @(posedge ext_clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      wsh_q       <= '0;
      rdata_q     <= '0;
      rpar_q      <= 1'b0;
      ack_q       <= '0;
      rnw_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_ack_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_perr_q  <= 1'b0;
      swdio_o_q   <= 1'b0;
      swdio_oe_q  <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;

      if (sample_tick) begin
        case (state_q)
          ACK:     ack_q[cnt_q[1:0]] <= swdio_i;
          RDATA:   if (cnt_q == 6'(DATA_BITS)) rpar_q <= swdio_i;
                   else rdata_q <= {swdio_i, rdata_q[31:1]};
          default: ;
        endcase
      end

      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            cnt_q       <= '0;
            ack_q       <= '0;
            rnw_q       <= cmd_rnw & ~cmd_lreset;
            wsh_q       <= {^cmd_wdata, cmd_wdata};
            req_q       <= req_word[7:1];
            swdio_oe_q  <= 1'b1;
            if (cmd_lreset) begin
              state_q   <= LRESET;
              swdio_o_q <= 1'b1;
            end else begin
              state_q   <= REQ;
              swdio_o_q <= req_word[0];
            end
          end
        end
        default: if (drive_tick) begin
          cnt_q <= cnt_q + 6'd1;
          case (state_q)
            LRESET: if (cnt_q == 6'(LRESET_BITS - 1)) begin
              state_q <= IDLE_CLK; cnt_q <= '0; swdio_o_q <= 1'b0;
            end
            REQ: if (cnt_q == 6'(REQ_BITS - 1)) begin
              state_q <= TRN1; cnt_q <= '0; swdio_oe_q <= 1'b0; swdio_o_q <= 1'b0;
            end else begin
              swdio_o_q <= req_q[0];
              req_q     <= {1'b0, req_q[6:1]};
            end
            TRN1: begin
              state_q <= ACK; cnt_q <= '0;
            end
            ACK: if (cnt_q == 6'(ACK_BITS - 1)) begin
              state_q <= (ack_q == ACK_OK && rnw_q) ? RDATA : TRN2;
              cnt_q   <= '0;
            end
            RDATA: if (cnt_q == 6'(DATA_BITS)) begin
              state_q <= TRN2; cnt_q <= '0;
            end
            TRN2: begin
              cnt_q      <= '0;
              swdio_oe_q <= 1'b1;
              if (ack_q == ACK_OK && !rnw_q) begin
                state_q   <= WDATA;
                swdio_o_q <= wsh_q[0];
                wsh_q     <= {1'b0, wsh_q[32:1]};
              end else begin
                state_q   <= IDLE_CLK;
                swdio_o_q <= 1'b0;
              end
            end
            WDATA: if (cnt_q == 6'(DATA_BITS)) begin
              state_q <= IDLE_CLK; cnt_q <= '0; swdio_o_q <= 1'b0;
            end else begin
              swdio_o_q <= wsh_q[0];
              wsh_q     <= {1'b0, wsh_q[32:1]};
            end
            IDLE_CLK: if (cnt_q == 6'(IDLE_CYCLES - 1)) begin
              state_q        <= DONE;
              cnt_q          <= '0;
              cmd_ready_q    <= 1'b1;
              rsp_valid_q    <= 1'b1;
              rsp_ack_q      <= ack_q;
              rsp_rdata_q    <= (ack_q == ACK_OK && rnw_q) ? rdata_q : '0;
              rsp_perr_q     <= (ack_q == ACK_OK && rnw_q) && (rpar_q != ^rdata_q);
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_ack        = rsp_ack_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_parity_err = rsp_perr_q;
  assign swdio_o        = swdio_o_q;
  assign swdio_oe       = swdio_oe_q;

endmodule

`default_nettype wire
